// File: rtl/seq_shift_unit.sv
// rtl/seq_shift_unit.sv - multicycle arithmetic-right / logical-left shift unit
//
// Purpose:
//   Resolves one shift-amount bit per cycle, MSB first (2^(SHAMT_BITS-1) down
//   to 1). Operand, amount, type and result are registered so the ALU result
//   mux sees a stable value behind a start/ready handshake.
//
// Ports:
//   clock          - rising-edge clock
//   reset          - asynchronous active-high reset
//   ctrl_start     - request pulse, sampled only while ctrl_busy is low
//   ctrl_shifttype - 0 = SLL, 1 = SRA
//   ctrl_shiftamt  - shift amount 0..WIDTH-1
//   data_operandA  - value to shift
//   ctrl_busy      - high while an operation is in flight
//   data_resultRDY - one-cycle pulse, data_result is valid
//   data_result    - shifted value, held until the next completion

module seq_shift_unit #(
  parameter int WIDTH      = 32,
  parameter int SHAMT_BITS = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ctrl_start,
  input  logic                  ctrl_shifttype,
  input  logic [SHAMT_BITS-1:0] ctrl_shiftamt,
  input  logic [WIDTH-1:0]      data_operandA,
  output logic                  ctrl_busy,
  output logic                  data_resultRDY,
  output logic [WIDTH-1:0]      data_result
);

  localparam int K_W = (SHAMT_BITS > 1) ? $clog2(SHAMT_BITS) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(SHAMT_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [WIDTH-1:0]        work_q, work_d;
  logic [SHAMT_BITS-1:0]   amt_q, amt_d;
  logic                    type_q, type_d;
  logic [K_W-1:0]          k_q, k_d;
  logic                    busy_q, busy_d;
  logic                    rdy_q, rdy_d;
  logic [WIDTH-1:0]        result_q, result_d;

  // One fixed-distance mux stage per amount bit; the counter picks which
  // stage is applied to the working register this cycle.
  logic [WIDTH-1:0] stage_sll [SHAMT_BITS];
  logic [WIDTH-1:0] stage_sra [SHAMT_BITS];
  logic [WIDTH-1:0] stage_out;

  genvar gi;
  generate
    for (gi = 0; gi < SHAMT_BITS; gi++) begin : g_stage
      assign stage_sll[gi] = work_q << (2 ** gi);
      // Fill comes from the working MSB, which is always the original sign.
      assign stage_sra[gi] = $unsigned($signed(work_q) >>> (2 ** gi));
    end
  endgenerate

  always_comb begin
    stage_out = work_q;
    if (amt_q[k_q]) begin
      stage_out = type_q ? stage_sra[k_q] : stage_sll[k_q];
    end
  end

  always_comb begin
    state_d  = state_q;
    work_d   = work_q;
    amt_d    = amt_q;
    type_d   = type_q;
    k_d      = k_q;
    busy_d   = busy_q;
    rdy_d    = 1'b0;
    result_d = result_q;

    case (state_q)
      // DONE accepts a new request just like IDLE, giving back-to-back issue.
      ST_IDLE, ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
        if (ctrl_start) begin
          work_d  = data_operandA;
          amt_d   = ctrl_shiftamt;
          type_d  = ctrl_shifttype;
          k_d     = K_LAST;
          busy_d  = 1'b1;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        work_d = stage_out;
        if (k_q == '0) begin
          result_d = stage_out;
          rdy_d    = 1'b1;
          busy_d   = 1'b0;
          state_d  = ST_DONE;
        end else begin
          k_d = k_q - K_W'(1);
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      work_q   <= '0;
      amt_q    <= '0;
      type_q   <= 1'b0;
      k_q      <= '0;
      busy_q   <= 1'b0;
      rdy_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      amt_q    <= amt_d;
      type_q   <= type_d;
      k_q      <= k_d;
      busy_q   <= busy_d;
      rdy_q    <= rdy_d;
      result_q <= result_d;
    end
  end

  assign ctrl_busy      = busy_q;
  assign data_resultRDY = rdy_q;
  assign data_result    = result_q;

endmodule

// File: tb/tb_seq_shift_unit.sv
// tb/tb_seq_shift_unit.sv - self-checking bench for seq_shift_unit

module tb_seq_shift_unit;

  logic        clock;
  logic        reset;
  logic        ctrl_start;
  logic        ctrl_shifttype;
  logic [4:0]  ctrl_shiftamt;
  logic [31:0] data_operandA;
  logic        ctrl_busy;
  logic        data_resultRDY;
  logic [31:0] data_result;

  int          checks;
  int          failures;
  logic [31:0] last_result;

  seq_shift_unit #(.WIDTH(32), .SHAMT_BITS(5)) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_start     (ctrl_start),
    .ctrl_shifttype (ctrl_shifttype),
    .ctrl_shiftamt  (ctrl_shiftamt),
    .data_operandA  (data_operandA),
    .ctrl_busy      (ctrl_busy),
    .data_resultRDY (data_resultRDY),
    .data_result    (data_result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Bit-by-bit reference: each result bit is picked from the operand position
  // it came from, or from the fill value when that position is off the end.
  function automatic logic [31:0] ref_shift(input logic [31:0] op, input logic [4:0] amt,
                                            input logic typ);
    logic [31:0] r;
    int a;
    a = int'(amt);
    for (int i = 0; i < 32; i++) begin
      if (typ) r[i] = (i + a < 32) ? op[i + a] : op[31];
      else     r[i] = (i >= a) ? op[i - a] : 1'b0;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic scramble_inputs();
    data_operandA  = $urandom;
    ctrl_shiftamt  = 5'($urandom_range(0, 31));
    ctrl_shifttype = 1'($urandom_range(0, 1));
  endtask

  // Called at a negedge with the DUT in IDLE or DONE; returns at the negedge
  // following the completion edge (the DONE cycle).
  task automatic run_op(input logic [31:0] op, input logic [4:0] amt, input logic typ,
                        input bit poke_mid, input string tag);
    logic [31:0] exp;
    exp = ref_shift(op, amt, typ);
    data_operandA  = op;
    ctrl_shiftamt  = amt;
    ctrl_shifttype = typ;
    ctrl_start     = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ctrl_start = 1'b0;
    scramble_inputs();
    check({tag, " busy@E0"}, 32'(ctrl_busy), 32'd1);
    check({tag, " rdy@E0"}, 32'(data_resultRDY), 32'd0);
    for (int e = 1; e <= 4; e++) begin
      if (poke_mid && e == 2) ctrl_start = 1'b1;
      else ctrl_start = 1'b0;
      @(posedge clock);
      @(negedge clock);
      scramble_inputs();
      check($sformatf("%s busy@E%0d", tag, e), 32'(ctrl_busy), 32'd1);
      check($sformatf("%s rdy@E%0d", tag, e), 32'(data_resultRDY), 32'd0);
      check($sformatf("%s hold@E%0d", tag, e), data_result, last_result);
    end
    ctrl_start = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check({tag, " busy@E5"}, 32'(ctrl_busy), 32'd0);
    check({tag, " rdy@E5"}, 32'(data_resultRDY), 32'd1);
    check({tag, " result"}, data_result, exp);
    last_result = exp;
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      @(negedge clock);
      check($sformatf("%s rdy idle%0d", tag, i), 32'(data_resultRDY), 32'd0);
      check($sformatf("%s busy idle%0d", tag, i), 32'(ctrl_busy), 32'd0);
      check($sformatf("%s hold idle%0d", tag, i), data_result, last_result);
      scramble_inputs();
    end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    last_result    = 32'h0;
    reset          = 1'b1;
    ctrl_start     = 1'b0;
    ctrl_shifttype = 1'b0;
    ctrl_shiftamt  = 5'd0;
    data_operandA  = 32'h0;

    #3;
    check("reset busy", 32'(ctrl_busy), 32'd0);
    check("reset rdy", 32'(data_resultRDY), 32'd0);
    check("reset result", data_result, 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    idle_cycles(2, "post_reset");

    run_op(32'h8000_0000, 5'd4, 1'b1, 1'b0, "sra_min_4");
    check("sra_min_4 const", data_result, 32'hF800_0000);
    idle_cycles(1, "a");
    run_op(32'h0000_0001, 5'd31, 1'b0, 1'b0, "sll_1_31");
    check("sll_1_31 const", data_result, 32'h8000_0000);
    idle_cycles(1, "b");
    run_op(32'h7FFF_FFFF, 5'd31, 1'b1, 1'b0, "sra_pos_31");
    check("sra_pos_31 const", data_result, 32'h0000_0000);
    idle_cycles(1, "c");
    run_op(32'h8000_0001, 5'd31, 1'b1, 1'b0, "sra_neg_31");
    check("sra_neg_31 const", data_result, 32'hFFFF_FFFF);
    idle_cycles(1, "d");
    run_op(32'h8000_0001, 5'd0, 1'b1, 1'b0, "sra_amt0");
    check("sra_amt0 const", data_result, 32'h8000_0001);
    idle_cycles(2, "e");

    // Back-to-back: second request issued in the DONE cycle, mid-SHIFT poke ignored.
    run_op(32'h0000_000F, 5'd4, 1'b0, 1'b0, "b2b_first");
    check("b2b_first const", data_result, 32'h0000_00F0);
    run_op(32'hF000_0000, 5'd8, 1'b1, 1'b1, "b2b_second");
    check("b2b_second const", data_result, 32'hFFF0_0000);
    idle_cycles(8, "no_third");

    // Asynchronous reset in the middle of an operation.
    data_operandA  = 32'h1234_5678;
    ctrl_shiftamt  = 5'd3;
    ctrl_shifttype = 1'b0;
    ctrl_start     = 1'b1;
    @(posedge clock);
    @(negedge clock);
    ctrl_start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    check("abort busy", 32'(ctrl_busy), 32'd0);
    check("abort rdy", 32'(data_resultRDY), 32'd0);
    check("abort result", data_result, 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset       = 1'b0;
    last_result = 32'h0;
    idle_cycles(4, "after_abort");
    run_op(32'hC000_0000, 5'd1, 1'b1, 1'b0, "sra_c0_1");
    check("sra_c0_1 const", data_result, 32'hE000_0000);
    idle_cycles(10, "hold_e0");

    // Randomised operations, a mix of idle gaps and back-to-back issue.
    for (int n = 0; n < 24; n++) begin
      logic [31:0] op;
      logic [4:0]  amt;
      logic        typ;
      op  = $urandom;
      amt = 5'($urandom_range(0, 31));
      typ = 1'($urandom_range(0, 1));
      run_op(op, amt, typ, bit'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
      if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 3)), "rnd_gap");
    end
    idle_cycles(3, "tail");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
